regfile_operand_sequencer: RTL and testbench



---
 rtl/regfile_operand_sequencer.sv | 98 +++++++++
 tb/tb_regfile_operand_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_operand_sequencer.sv
// regfile_operand_sequencer: fetches two operands from the register file and presents them to the ALU; the writeback path runs independently.
// Define REGFILE_BYPASS_EN to forward a pending write into the operands instead of stalling ISSUE.
module regfile_operand_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src_a,
  input  logic [ADDR_W-1:0] req_src_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_readA_address,
  output logic [ADDR_W-1:0] rf_readB_address,
  input  logic [DATA_W-1:0] rf_reg_A,
  input  logic [DATA_W-1:0] rf_reg_B,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_value
);
  typedef enum logic [1:0] {IDLE, ISSUE, PRESENT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, wv_q, wv_d;
  logic wr_q, wr_d, hit_a, hit_b;
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    // The register file reads and writes on the same falling edge, so a read that matches a pending write returns the old value.
    hit_a   = wr_q && wa_q == ra_q;
    hit_b   = wr_q && wa_q == rb_q;
    wr_d    = wb_valid;
    wa_d    = wb_valid ? wb_addr : wa_q;
    wv_d    = wb_valid ? wb_data : wv_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        ra_d    = req_src_a;
        rb_d    = req_src_b;
        state_d = ISSUE;
      end
`ifdef REGFILE_BYPASS_EN
      ISSUE: begin
        opa_d   = hit_a ? wv_q : rf_reg_A;
        opb_d   = hit_b ? wv_q : rf_reg_B;
        state_d = PRESENT;
      end
`else
      ISSUE: if (!(hit_a || hit_b)) begin
        opa_d   = rf_reg_A;
        opb_d   = rf_reg_B;
        state_d = PRESENT;
      end
`endif
      PRESENT: state_d = op_ready ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      wv_q    <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      wv_q    <= wv_d;
    end
  end
  assign req_ready        = state_q == IDLE;
  assign op_valid         = state_q == PRESENT;
  assign op_a             = opa_q;
  assign op_b             = opb_q;
  assign rf_readA_address = ra_q;
  assign rf_readB_address = rb_q;
  assign rf_write         = wr_q;
  assign rf_write_address = wa_q;
  assign rf_write_value   = wv_q;
endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// tb_regfile_operand_sequencer: directed checks of fetch, backpressure, writeback, hazard handling and async reset.
module tb_regfile_operand_sequencer;
  logic        CLK, RST_N;
  logic        req_valid, req_ready, op_valid, op_ready, wb_valid, rf_write;
  logic [2:0]  req_src_a, req_src_b, wb_addr, rf_readA_address, rf_readB_address, rf_write_address;
  logic [15:0] op_a, op_b, wb_data, rf_reg_A, rf_reg_B, rf_write_value;
  logic [15:0] mem [8];
  logic        rf_init_done = 1'b0;
  int          checks = 0, failures = 0;

  regfile_operand_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_src_a(req_src_a), .req_src_b(req_src_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_readA_address(rf_readA_address), .rf_readB_address(rf_readB_address),
    .rf_reg_A(rf_reg_A), .rf_reg_B(rf_reg_B),
    .rf_write(rf_write), .rf_write_address(rf_write_address), .rf_write_value(rf_write_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: reads return the pre-write contents on the shared falling edge.
  always @(negedge CLK) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 8; i++) mem[i] <= (i == 1) ? 16'h03FF : 16'h0000;
      rf_init_done <= 1'b1;
    end else if (rf_write) mem[rf_write_address] <= rf_write_value;
    rf_reg_A <= mem[rf_readA_address];
    rf_reg_B <= mem[rf_readB_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input int exp_lat,
                       input logic [15:0] ea, input logic [15:0] eb, input bit ack);
    int lat;
    req_valid = 1'b1;
    req_src_a = a;
    req_src_b = b;
    step();
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    lat = 1;
    while (!op_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("op_a", op_a, ea);
    check("op_b", op_b, eb);
    check("req_ready_busy", req_ready, 0);
    if (ack) begin
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      check("op_valid_after_ack", op_valid, 0);
      check("req_ready_after_ack", req_ready, 1);
    end
  endtask

  initial begin
    int wcount;
    int hz_lat;
`ifdef REGFILE_BYPASS_EN
    hz_lat = 2;
`else
    hz_lat = 3;
`endif
    RST_N = 1'b0;
    req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
    req_src_a = '0; req_src_b = '0; wb_addr = '0; wb_data = '0;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_ab", {op_a, op_b}, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_rf_addrs", {rf_readA_address, rf_readB_address, rf_write_address}, 0);
    check("rst_rf_value", rf_write_value, 0);
    RST_N = 1'b1;
    step();

    fetch(3'd1, 3'd0, 2, 16'h03FF, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_op_valid", op_valid, 1);
      check("bp_ops_stable", {op_a, op_b}, {16'h03FF, 16'h0000});
      check("bp_req_ready", req_ready, 0);
    end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("bp_release_valid", op_valid, 0);
    check("bp_release_ready", req_ready, 1);

    wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    step();
    wb_valid = 1'b0;
    check("wb_rf_write", rf_write, 1);
    check("wb_rf_addr", rf_write_address, 3);
    check("wb_rf_value", rf_write_value, 16'hBEEF);
    step();
    check("wb_rf_write_drop", rf_write, 0);
    check("wb_rf_value_hold", rf_write_value, 16'hBEEF);
    fetch(3'd3, 3'd1, 2, 16'hBEEF, 16'h03FF, 1'b1);

    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
    fetch(3'd5, 3'd5, hz_lat, 16'h1234, 16'h1234, 1'b1);

    wcount = 0;
    wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
    step();
    wcount += int'(rf_write);
    wb_data = 16'h0002;
    step();
    wcount += int'(rf_write);
    check("b2b_value", rf_write_value, 16'h0002);
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      wcount += int'(rf_write);
    end
    check("b2b_write_cycles", wcount, 2);
    fetch(3'd2, 3'd3, 2, 16'h0002, 16'hBEEF, 1'b1);

    fetch(3'd1, 3'd2, 2, 16'h03FF, 16'h0002, 1'b0);
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h7777;
    step();
    wb_valid = 1'b0;
    check("pre_rst_rf_write", rf_write, 1);
    check("pre_rst_op_valid", op_valid, 1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_op_valid", op_valid, 0);
    check("arst_rf_write", rf_write, 0);
    check("arst_op_a", op_a, 0);
    #2 RST_N = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1);
    fetch(3'd6, 3'd1, 2, 16'h0000, 16'h03FF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
